// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_debounce input conditioner.
package sync_pkg;

    localparam int c_MIN_STAGES = 2;

    // Counter width is ceil(log2(depth)) but never narrower than one bit.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: synchronizer chain, stability counter and output/strobe registers.
// Strobe registers exist only when SYNC_DEBOUNCE_EDGE_EN is defined.
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int p_STAGES          = 2,
    parameter int p_DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_input,
    output logic o_output,
    output logic o_rise,
    output logic o_fall
);

    localparam int                lp_CW      = cnt_width(p_DEBOUNCE_CYCLES);
    localparam logic [lp_CW-1:0]  lp_CNT_MAX = lp_CW'(p_DEBOUNCE_CYCLES - 1);

    logic [p_STAGES-1:0] r_sync;
    logic [lp_CW-1:0]    r_cnt;
    logic                r_output;
    logic                w_s;
    logic                w_differ;
    logic                w_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[p_STAGES-2:0], i_input};
        end
    end

    assign w_s      = r_sync[p_STAGES-1];
    assign w_differ = (w_s != r_output);
    assign w_accept = w_differ && (r_cnt == lp_CNT_MAX);

    // A return to the current level discards any partial count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_output <= 1'b0;
        end else if (!w_differ) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_output <= w_s;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_output = r_output;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept &  w_s;
            r_fall <= w_accept & ~w_s;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer plus debounce filter; edge strobes gated by
// SYNC_DEBOUNCE_EDGE_EN (ports always present, tied low when undefined).
module sync_debounce
    import sync_pkg::*;
#(
    parameter int p_WIDTH           = 1,
    parameter int p_STAGES          = 2,
    parameter int p_DEBOUNCE_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_WIDTH-1:0] iv_input,
    output logic [p_WIDTH-1:0] ov_output,
    output logic [p_WIDTH-1:0] ov_rise,
    output logic [p_WIDTH-1:0] ov_fall
);

    if (p_STAGES < c_MIN_STAGES || p_DEBOUNCE_CYCLES < 1) begin : g_param_check
        $fatal(1, "sync_debounce: p_STAGES must be >= 2 and p_DEBOUNCE_CYCLES >= 1");
    end

    for (genvar g = 0; g < p_WIDTH; g++) begin : g_chan
        sync_debounce_channel #(
            .p_STAGES          (p_STAGES),
            .p_DEBOUNCE_CYCLES (p_DEBOUNCE_CYCLES)
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_input  (iv_input[g]),
            .o_output (ov_output[g]),
            .o_rise   (ov_rise[g]),
            .o_fall   (ov_fall[g])
        );
    end

endmodule
